// File: rtl/ps2_tx_if.sv
// Host command handshake for the PS/2 transmitter.
// The master issues tx_start/tx_data; the slave reports busy/done/error.
interface ps2_tx_if;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_error;

    modport master (
        output tx_start,
        output tx_data,
        input  tx_busy,
        input  tx_done,
        input  tx_error
    );

    modport slave (
        input  tx_start,
        input  tx_data,
        output tx_busy,
        output tx_done,
        output tx_error
    );
endinterface

// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send,
// 8 data bits + odd parity + stop on device clocks, then ACK check.
module ps2_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int REQ_CYCLES     = 500,
    parameter int TIMEOUT_CYCLES = 1500000
) (
    input  logic clk,
    input  logic reset,
    ps2_tx_if.slave bus,
    input  logic ps2_clk_in,
    input  logic ps2_data_in,
    output logic ps2_clk_oe,
    output logic ps2_data_oe
);

    localparam int MAX_A = (INHIBIT_CYCLES > REQ_CYCLES) ?
                           INHIBIT_CYCLES : REQ_CYCLES;
    localparam int MAX_P = (MAX_A > TIMEOUT_CYCLES) ?
                           MAX_A : TIMEOUT_CYCLES;
    localparam int CW    = $clog2(MAX_P) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SHIFT,
        S_ACK,
        S_WAIT
    } state_t;

    state_t        r_state, w_state_n;
    logic [CW-1:0] r_cnt, w_cnt_n;
    logic [3:0]    r_bit, w_bit_n;
    logic [7:0]    r_data, w_data_n;
    logic          r_clk_oe, w_clk_oe_n;
    logic          r_data_oe, w_data_oe_n;
    logic          r_busy, w_busy_n;
    logic          r_done, w_done_n;
    logic          r_err, w_err_n;

    logic r_clk_s1, r_clk_s2, r_clk_prev;
    logic r_dat_s1, r_dat_s2;

    logic       w_fall;
    logic       w_timeout;
    logic [3:0] w_bit_inc;
    logic       w_bit_val;

    // Sync flops idle high so reset never fakes a falling edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
        end else begin
            r_clk_s1   <= ps2_clk_in;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_dat_s1   <= ps2_data_in;
            r_dat_s2   <= r_dat_s1;
        end
    end

    assign w_fall    = r_clk_prev & ~r_clk_s2;
    assign w_timeout = (r_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign w_bit_inc = r_bit + 4'd1;
    assign w_bit_val = (w_bit_inc == 4'd9)  ? ~^r_data :
                       (w_bit_inc == 4'd10) ? 1'b1 :
                       r_data[r_bit[2:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_data    <= '0;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_cnt     <= w_cnt_n;
            r_bit     <= w_bit_n;
            r_data    <= w_data_n;
            r_clk_oe  <= w_clk_oe_n;
            r_data_oe <= w_data_oe_n;
            r_busy    <= w_busy_n;
            r_done    <= w_done_n;
            r_err     <= w_err_n;
        end
    end

    // Outputs are computed for the next state and registered
    always_comb begin
        w_state_n   = r_state;
        w_cnt_n     = r_cnt + CW'(1);
        w_bit_n     = r_bit;
        w_data_n    = r_data;
        w_clk_oe_n  = 1'b0;
        w_data_oe_n = 1'b0;
        w_busy_n    = 1'b0;
        w_done_n    = 1'b0;
        w_err_n     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_cnt_n = '0;
                // r_busy is still high in the done/error cycle
                if (bus.tx_start && !r_busy) begin
                    w_state_n  = S_INHIBIT;
                    w_data_n   = bus.tx_data;
                    w_clk_oe_n = 1'b1;
                    w_busy_n   = 1'b1;
                end
            end
            S_INHIBIT: begin
                w_busy_n   = 1'b1;
                w_clk_oe_n = 1'b1;
                if (r_cnt == CW'(INHIBIT_CYCLES - 1)) begin
                    w_state_n   = S_REQ;
                    w_cnt_n     = '0;
                    w_data_oe_n = 1'b1;
                end
            end
            S_REQ: begin
                w_busy_n    = 1'b1;
                w_clk_oe_n  = 1'b1;
                w_data_oe_n = 1'b1;
                if (r_cnt == CW'(REQ_CYCLES - 1)) begin
                    w_state_n  = S_SHIFT;
                    w_cnt_n    = '0;
                    w_bit_n    = '0;
                    w_clk_oe_n = 1'b0;
                end
            end
            S_SHIFT: begin
                w_busy_n    = 1'b1;
                w_data_oe_n = r_data_oe;
                if (w_fall) begin
                    w_cnt_n     = '0;
                    w_bit_n     = w_bit_inc;
                    w_data_oe_n = ~w_bit_val;
                    if (w_bit_inc == 4'd10) begin
                        w_state_n = S_ACK;
                    end
                end else if (w_timeout) begin
                    w_state_n   = S_IDLE;
                    w_data_oe_n = 1'b0;
                    w_err_n     = 1'b1;
                end
            end
            S_ACK: begin
                w_busy_n = 1'b1;
                if (w_fall) begin
                    w_cnt_n = '0;
                    if (!r_dat_s2) begin
                        w_state_n = S_WAIT;
                    end else begin
                        w_state_n = S_IDLE;
                        w_err_n   = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_state_n = S_IDLE;
                    w_err_n   = 1'b1;
                end
            end
            S_WAIT: begin
                w_busy_n = 1'b1;
                if (r_clk_s2 && r_dat_s2) begin
                    w_state_n = S_IDLE;
                    w_done_n  = 1'b1;
                end else if (w_fall) begin
                    w_cnt_n = '0;
                end else if (w_timeout) begin
                    w_state_n = S_IDLE;
                    w_err_n   = 1'b1;
                end
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

    assign ps2_clk_oe   = r_clk_oe;
    assign ps2_data_oe  = r_data_oe;
    assign bus.tx_busy  = r_busy;
    assign bus.tx_done  = r_done;
    assign bus.tx_error = r_err;

endmodule
